// File: rtl/dram_sequencer.sv
// dram_sequencer: clocked RAS/MUX/CAS/WE sequencer for the slot-3 64Kx1 DRAM.
// Arbitrates CPU accesses, Z80 RAS-only refresh and an internal watchdog
// refresh, stalling the CPU through nwait while the internal refresh owns
// the array.
module dram_sequencer #(
    parameter int unsigned T_RM       = 2,
    parameter int unsigned T_MC       = 1,
    parameter int unsigned T_PRE      = 3,
    parameter int unsigned T_IREF     = 4,
    parameter int unsigned REF_PERIOD = 336
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        nmreq,
    input  logic        nrd,
    input  logic        nwr,
    input  logic        nrfshd,
    input  logic        nsltsl3,
    input  logic [15:0] addr,
    output logic [7:0]  ma,
    output logic        nras,
    output logic        ncas,
    output logic        nwe,
    output logic        mux,
    output logic        nwait
);

    localparam int unsigned TW = $clog2(REF_PERIOD);
    localparam logic [TW-1:0] TIMER_LAST = TW'(REF_PERIOD - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_ROW,
        S_COL,
        S_CAS,
        S_ZREF,
        S_IREF,
        S_PRE
    } state_t;

    state_t        state_q, state_d;
    logic [7:0]    cnt_q, cnt_d;
    logic          nras_q, nras_d;
    logic          ncas_q, ncas_d;
    logic          nwe_q, nwe_d;
    logic          mux_q, mux_d;
    logic [7:0]    ref_row_q, ref_row_d;
    logic [TW-1:0] ref_timer_q, ref_timer_d;
    logic          ref_pend_q, ref_pend_d;

    logic acc_req;
    logic ref_req;
    logic enter_ref;
    logic enter_iref;
    logic to_pre;

    // nrd carries no timing information: a read is any access with nwr high at CAS.
    logic unused_nrd;
    assign unused_nrd = nrd;

    assign acc_req = !nmreq && !nsltsl3 && nrfshd;
    assign ref_req = !nmreq && !nrfshd;

    // State, strobe and refresh-watchdog registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= S_IDLE;
            cnt_q       <= '0;
            nras_q      <= 1'b1;
            ncas_q      <= 1'b1;
            nwe_q       <= 1'b1;
            mux_q       <= 1'b0;
            ref_row_q   <= '0;
            ref_timer_q <= '0;
            ref_pend_q  <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            nras_q      <= nras_d;
            ncas_q      <= ncas_d;
            nwe_q       <= nwe_d;
            mux_q       <= mux_d;
            ref_row_q   <= ref_row_d;
            ref_timer_q <= ref_timer_d;
            ref_pend_q  <= ref_pend_d;
        end
    end

    // Next-state, registered strobe values and watchdog update.
    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        nras_d      = nras_q;
        ncas_d      = ncas_q;
        nwe_d       = nwe_q;
        mux_d       = mux_q;
        ref_row_d   = ref_row_q;
        ref_timer_d = ref_timer_q;
        ref_pend_d  = ref_pend_q;
        enter_ref   = 1'b0;
        enter_iref  = 1'b0;
        to_pre      = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (ref_req) begin
                    state_d   = S_ZREF;
                    nras_d    = 1'b0;
                    mux_d     = 1'b0;
                    enter_ref = 1'b1;
                end else if (ref_pend_q) begin
                    state_d    = S_IREF;
                    nras_d     = 1'b0;
                    mux_d      = 1'b0;
                    cnt_d      = '0;
                    enter_ref  = 1'b1;
                    enter_iref = 1'b1;
                end else if (acc_req) begin
                    state_d = S_ROW;
                    nras_d  = 1'b0;
                    mux_d   = 1'b0;
                    cnt_d   = '0;
                end
            end
            S_ROW: begin
                if (nmreq) begin
                    to_pre = 1'b1;
                end else if (cnt_q == 8'(T_RM - 1)) begin
                    state_d = S_COL;
                    mux_d   = 1'b1;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + 8'd1;
                end
            end
            S_COL: begin
                if (nmreq) begin
                    to_pre = 1'b1;
                end else if (cnt_q == 8'(T_MC - 1)) begin
                    state_d = S_CAS;
                    ncas_d  = 1'b0;
                    nwe_d   = nwr;
                end else begin
                    cnt_d = cnt_q + 8'd1;
                end
            end
            S_CAS, S_ZREF: begin
                if (nmreq) begin
                    to_pre = 1'b1;
                end
            end
            S_IREF: begin
                if (cnt_q == 8'(T_IREF - 1)) begin
                    to_pre    = 1'b1;
                    ref_row_d = ref_row_q + 8'd1;
                end else begin
                    cnt_d = cnt_q + 8'd1;
                end
            end
            S_PRE: begin
                if (cnt_q == 8'(T_PRE - 1)) begin
                    state_d = S_IDLE;
                end else begin
                    cnt_d = cnt_q + 8'd1;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        if (to_pre) begin
            state_d = S_PRE;
            nras_d  = 1'b1;
            ncas_d  = 1'b1;
            nwe_d   = 1'b1;
            mux_d   = 1'b0;
            cnt_d   = '0;
        end

        // Timer saturates at its last value, which also keeps the pending flag
        // asserted; a Z80 refresh restarts the timer but leaves a pending
        // internal refresh outstanding.
        if (enter_ref) begin
            ref_timer_d = '0;
        end else if (ref_timer_q != TIMER_LAST) begin
            ref_timer_d = ref_timer_q + TW'(1);
        end

        if (enter_iref) begin
            ref_pend_d = 1'b0;
        end else if (ref_timer_q == TIMER_LAST) begin
            ref_pend_d = 1'b1;
        end
    end

    // DRAM address mux and CPU wait generation.
    always_comb begin
        if (state_q == S_IREF) begin
            ma = ref_row_q;
        end else if (mux_q) begin
            ma = addr[15:8];
        end else begin
            ma = addr[7:0];
        end

        nwait = 1'b1;
        if (acc_req && ((state_q == S_IREF) || (state_q == S_PRE) ||
                        ((state_q == S_IDLE) && ref_pend_q && !ref_req))) begin
            nwait = 1'b0;
        end
    end

    assign nras = nras_q;
    assign ncas = ncas_q;
    assign nwe  = nwe_q;
    assign mux  = mux_q;

endmodule

// File: tb/tb_dram_sequencer.sv
// tb_dram_sequencer: directed bench for the DRAM sequencer. A second instance
// with a short refresh period exercises refresh-row wrap-around.
module tb_dram_sequencer;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        nmreq = 1'b1;
    logic        nrd = 1'b1;
    logic        nwr = 1'b1;
    logic        nrfshd = 1'b1;
    logic        nsltsl3 = 1'b1;
    logic [15:0] addr = 16'h1234;
    logic [7:0]  ma;
    logic        nras, ncas, nwe, mux, nwait;

    logic        rst2 = 1'b1;
    logic        hi = 1'b1;
    logic [15:0] addr2 = 16'h0000;
    logic [7:0]  ma2;
    logic        nras2, ncas2, nwe2, mux2, nwait2;

    int n_vec = 0;
    int n_err = 0;

    logic [4:0] ctl;
    assign ctl = {nras, ncas, nwe, mux, nwait};

    dram_sequencer dut (
        .clk(clk), .rst(rst), .nmreq(nmreq), .nrd(nrd), .nwr(nwr),
        .nrfshd(nrfshd), .nsltsl3(nsltsl3), .addr(addr), .ma(ma),
        .nras(nras), .ncas(ncas), .nwe(nwe), .mux(mux), .nwait(nwait)
    );

    dram_sequencer #(.REF_PERIOD(8)) dut2 (
        .clk(clk), .rst(rst2), .nmreq(hi), .nrd(hi), .nwr(hi),
        .nrfshd(hi), .nsltsl3(hi), .addr(addr2), .ma(ma2),
        .nras(nras2), .ncas(ncas2), .nwe(nwe2), .mux(mux2), .nwait(nwait2)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic bus_idle();
        nmreq = 1'b1; nsltsl3 = 1'b1; nrfshd = 1'b1; nrd = 1'b1; nwr = 1'b1;
    endtask

    task automatic cpu_acc(input logic [15:0] a, input logic wr_n);
        addr = a; nwr = wr_n; nrd = ~wr_n;
        nmreq = 1'b0; nsltsl3 = 1'b0; nrfshd = 1'b1;
    endtask

    task automatic test_reset();
        rst = 1'b1; addr = 16'h1234; bus_idle();
        tick(); tick();
        if (ctl !== 5'b11101) begin $display("FAIL reset_ctl got %b exp %b", ctl, 5'b11101); n_err++; end
        n_vec++;
        if (ma !== 8'h34) begin $display("FAIL reset_ma got %h exp %h", ma, 8'h34); n_err++; end
        n_vec++;
        if (dut.ref_row_q !== 8'h00 || dut.ref_timer_q !== '0 || dut.ref_pend_q !== 1'b0) begin
            $display("FAIL reset_refstate got row=%h timer=%0d pend=%b exp 00/0/0",
                     dut.ref_row_q, dut.ref_timer_q, dut.ref_pend_q);
            n_err++;
        end
        n_vec++;
        rst = 1'b0;
    endtask

    // Last reset edge is R; the watchdog raises pending at edge R+336.
    task automatic test_internal_refresh();
        repeat (335) tick();
        cpu_acc(16'h1234, 1'b1); #1;
        if (nwait !== 1'b1) begin $display("FAIL wdog_not_yet got %b exp 1", nwait); n_err++; end
        n_vec++;
        bus_idle();
        tick();
        cpu_acc(16'h1234, 1'b1); #1;
        if (nwait !== 1'b0) begin $display("FAIL wdog_pending_stall got %b exp 0", nwait); n_err++; end
        n_vec++;
        tick();
        if ({nras, ncas, mux, nwait} !== 4'b0100) begin
            $display("FAIL iref_entry got %b exp %b", {nras, ncas, mux, nwait}, 4'b0100); n_err++;
        end
        n_vec++;
        if (ma !== 8'h00) begin $display("FAIL iref_ma got %h exp 00", ma); n_err++; end
        n_vec++;
        for (int i = 0; i < 3; i++) begin
            tick();
            if (nras !== 1'b0) begin $display("FAIL iref_hold[%0d] got %b exp 0", i, nras); n_err++; end
            n_vec++;
        end
        tick();
        if (ctl !== 5'b11100) begin $display("FAIL iref_pre got %b exp %b", ctl, 5'b11100); n_err++; end
        n_vec++;
        tick(); tick();
        if (ctl !== 5'b11100) begin $display("FAIL iref_pre_end got %b exp %b", ctl, 5'b11100); n_err++; end
        n_vec++;
        tick();
        if (ctl !== 5'b11101) begin $display("FAIL iref_idle_release got %b exp %b", ctl, 5'b11101); n_err++; end
        n_vec++;
        tick();
        if ({nras, nwait} !== 2'b01) begin $display("FAIL post_iref_row got %b exp 01", {nras, nwait}); n_err++; end
        n_vec++;
        if (dut.ref_row_q !== 8'h01) begin $display("FAIL ref_row_inc got %h exp 01", dut.ref_row_q); n_err++; end
        n_vec++;
        bus_idle();
        tick();
        repeat (3) tick();
    endtask

    // Read at edge E, then a write presented during PRE is accepted at E+14.
    task automatic test_back_to_back();
        cpu_acc(16'hA55A, 1'b1);
        tick();
        if ({nras, ncas, mux} !== 3'b010 || ma !== 8'h5A) begin
            $display("FAIL rd_row got %b/%h exp 010/5a", {nras, ncas, mux}, ma); n_err++;
        end
        n_vec++;
        tick();
        if (mux !== 1'b0) begin $display("FAIL rd_row_hold got %b exp 0", mux); n_err++; end
        n_vec++;
        tick();
        if ({nras, ncas, mux} !== 3'b011 || ma !== 8'hA5) begin
            $display("FAIL rd_col got %b/%h exp 011/a5", {nras, ncas, mux}, ma); n_err++;
        end
        n_vec++;
        tick();
        if ({nras, ncas, nwe, mux} !== 4'b0011) begin
            $display("FAIL rd_cas got %b exp 0011", {nras, ncas, nwe, mux}); n_err++;
        end
        n_vec++;
        repeat (6) tick();
        if (ncas !== 1'b0) begin $display("FAIL rd_cas_hold got %b exp 0", ncas); n_err++; end
        n_vec++;
        bus_idle();
        tick();
        if (ctl !== 5'b11101) begin $display("FAIL rd_pre got %b exp %b", ctl, 5'b11101); n_err++; end
        n_vec++;
        tick(); tick();
        cpu_acc(16'hA55A, 1'b0); #1;
        if (nwait !== 1'b0) begin $display("FAIL pre_stall got %b exp 0", nwait); n_err++; end
        n_vec++;
        tick();
        if ({nras, nwait} !== 2'b11) begin $display("FAIL pre_no_accept got %b exp 11", {nras, nwait}); n_err++; end
        n_vec++;
        tick();
        if (nras !== 1'b0) begin $display("FAIL wr_row got %b exp 0", nras); n_err++; end
        n_vec++;
        tick();
        if (ma !== 8'h5A || mux !== 1'b0) begin $display("FAIL wr_row_ma got %h/%b exp 5a/0", ma, mux); n_err++; end
        n_vec++;
        tick(); tick();
        if ({ncas, nwe} !== 2'b00) begin $display("FAIL wr_cas got %b exp 00", {ncas, nwe}); n_err++; end
        n_vec++;
        tick(); tick();
        if (nwe !== 1'b0) begin $display("FAIL wr_nwe_hold got %b exp 0", nwe); n_err++; end
        n_vec++;
        bus_idle();
        tick();
        if (ctl !== 5'b11101) begin $display("FAIL wr_pre got %b exp %b", ctl, 5'b11101); n_err++; end
        n_vec++;
        repeat (3) tick();
    endtask

    task automatic test_zref();
        nmreq = 1'b0; nrfshd = 1'b0; nsltsl3 = 1'b1; addr = 16'h007F;
        tick();
        if ({nras, ncas, mux, nwait} !== 4'b0101 || ma !== 8'h7F) begin
            $display("FAIL zref_entry got %b/%h exp 0101/7f", {nras, ncas, mux, nwait}, ma); n_err++;
        end
        n_vec++;
        if (dut.ref_timer_q !== '0) begin $display("FAIL zref_timer got %0d exp 0", dut.ref_timer_q); n_err++; end
        n_vec++;
        for (int i = 0; i < 3; i++) begin
            tick();
            if ({nras, ncas} !== 2'b01) begin $display("FAIL zref_hold[%0d] got %b exp 01", i, {nras, ncas}); n_err++; end
            n_vec++;
        end
        bus_idle();
        tick();
        if (ctl !== 5'b11101) begin $display("FAIL zref_pre got %b exp %b", ctl, 5'b11101); n_err++; end
        n_vec++;
        repeat (3) tick();
    endtask

    task automatic test_abort();
        cpu_acc(16'h4321, 1'b1);
        tick();
        if (nras !== 1'b0) begin $display("FAIL abort_row got %b exp 0", nras); n_err++; end
        n_vec++;
        bus_idle();
        tick();
        if (ctl !== 5'b11101) begin $display("FAIL abort_pre got %b exp %b", ctl, 5'b11101); n_err++; end
        n_vec++;
        for (int i = 0; i < 3; i++) begin
            tick();
            if ({nras, ncas} !== 2'b11) begin $display("FAIL abort_no_cas[%0d] got %b exp 11", i, {nras, ncas}); n_err++; end
            n_vec++;
        end
    endtask

    task automatic test_rst_cas();
        cpu_acc(16'hBEEF, 1'b0);
        repeat (4) tick();
        if ({ncas, nwe} !== 2'b00) begin $display("FAIL rstcas_cas got %b exp 00", {ncas, nwe}); n_err++; end
        n_vec++;
        rst = 1'b1;
        tick();
        if (ctl !== 5'b11101) begin $display("FAIL rst_cas_ctl got %b exp %b", ctl, 5'b11101); n_err++; end
        n_vec++;
        if (dut.ref_row_q !== 8'h00) begin $display("FAIL rst_ref_row got %h exp 00", dut.ref_row_q); n_err++; end
        n_vec++;
        rst = 1'b0;
        bus_idle();
        tick();
    endtask

    // Internal refresh k (counted from reset) must present row k mod 256.
    task automatic test_wrap();
        int   k = 0;
        int   cyc = 0;
        logic prev = 1'b1;
        rst2 = 1'b1;
        tick();
        rst2 = 1'b0;
        while (k <= 256 && cyc < 4000) begin
            tick();
            cyc++;
            if (prev && !nras2) begin
                if (k == 0 || k == 1 || k == 255 || k == 256) begin
                    if (ma2 !== k[7:0]) begin $display("FAIL wrap_row[%0d] got %h exp %h", k, ma2, k[7:0]); n_err++; end
                    n_vec++;
                end
                k++;
            end
            prev = nras2;
        end
        if (k <= 256) begin $display("FAIL wrap_timeout got %0d refreshes exp 257", k); n_err++; end
        n_vec++;
    endtask

    initial begin
        test_reset();
        test_internal_refresh();
        test_back_to_back();
        test_zref();
        test_abort();
        test_rst_cas();
        test_wrap();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
